// File: rtl/iterative_alu_if.sv
// iterative_alu_if: request/response handshake bundle for iterative_alu
interface iterative_alu_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [4:0] operation;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] result;
  modport master(output in_valid, operation, operand_1, operand_2, out_ready, input in_ready, out_valid, result);
  modport slave(input in_valid, operation, operand_1, operand_2, out_ready, output in_ready, out_valid, result);
endinterface

// File: rtl/iterative_alu.sv
// iterative_alu: RV32I/M ALU with single-cycle base ops and shift-add multiply / restoring divide
module iterative_alu #(parameter int WIDTH = 32) (
  input logic clock,
  input logic reset,
  iterative_alu_if.slave bus
);
  localparam int SHAMT_WIDTH = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [4:0] op_q, op_d, op;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, pfix;
  logic [CW-1:0] cnt_q, cnt_d;
  logic neg_q, neg_d;
  logic [WIDTH-1:0] x, y, mag1, mag2, sra, alu, fin;
  logic s1, s2, is_mul, is_div, div0, ovf, slt, sltu, iter;
  logic [WIDTH:0] msum, dsh, ddiff;
  assign x = bus.operand_1;
  assign y = bus.operand_2;
  assign op = bus.operation;
  assign s1 = x[WIDTH-1] && (op == 5'd11 || op == 5'd12 || op == 5'd14 || op == 5'd16);
  assign s2 = y[WIDTH-1] && (op == 5'd11 || op == 5'd14 || op == 5'd16);
  assign mag1 = s1 ? -x : x;
  assign mag2 = s2 ? -y : y;
  assign is_mul = op >= 5'd10 && op <= 5'd13;
  assign is_div = op >= 5'd14 && op <= 5'd17;
  assign div0 = is_div && y == '0;
  assign ovf = (op == 5'd14 || op == 5'd16) && x == {1'b1, {(WIDTH-1){1'b0}}} && y == '1;
  assign iter = (is_mul || is_div) && !div0 && !ovf;
  assign slt = $signed(x) < $signed(y);
  assign sltu = x < y;
  assign sra = $signed(x) >>> y[SHAMT_WIDTH-1:0];
  assign alu = op == 5'd0 ? x + y :
               op == 5'd1 ? x - y :
               op == 5'd2 ? x << y[SHAMT_WIDTH-1:0] :
               op == 5'd3 ? {{(WIDTH-1){1'b0}}, slt} :
               op == 5'd4 ? {{(WIDTH-1){1'b0}}, sltu} :
               op == 5'd5 ? x ^ y :
               op == 5'd6 ? x >> y[SHAMT_WIDTH-1:0] :
               op == 5'd7 ? sra :
               op == 5'd8 ? x | y :
               op == 5'd9 ? x & y :
               div0 ? ((op == 5'd14 || op == 5'd15) ? '1 : x) :
               ovf ? (op == 5'd14 ? x : '0) : '0;
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign dsh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign ddiff = dsh - {1'b0, b_q};
  assign step = op_q < 5'd14 ? {msum, acc_q[WIDTH-1:1]} :
                ddiff[WIDTH] ? {dsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0} :
                {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
  assign pfix = neg_q ? -step : step;
  assign fin = op_q == 5'd10 ? pfix[WIDTH-1:0] :
               op_q < 5'd14 ? pfix[2*WIDTH-1:WIDTH] :
               op_q < 5'd16 ? (neg_q ? -step[WIDTH-1:0] : step[WIDTH-1:0]) :
               (neg_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH]);
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    result_d = result_q;
    if (state_q == IDLE && bus.in_valid) begin
      op_d = op;
      a_d = mag1;
      b_d = mag2;
      neg_d = op >= 5'd16 ? s1 : s1 ^ s2;
      acc_d = {{WIDTH{1'b0}}, is_mul ? mag2 : mag1};
      state_d = iter ? BUSY : DONE;
      cnt_d = iter ? CW'(WIDTH) : cnt_q;
      result_d = iter ? result_q : alu;
    end else if (state_q == BUSY) begin
      acc_d = step;
      cnt_d = cnt_q - CW'(1);
      state_d = cnt_q == CW'(1) ? DONE : BUSY;
      result_d = cnt_q == CW'(1) ? fin : result_q;
    end else if (state_q == DONE && bus.out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      result_q <= result_d;
    end
  end
  assign bus.in_ready = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.result = result_q;
endmodule

// File: tb/tb_iterative_alu.sv
// tb_iterative_alu: directed checks of iterative_alu at WIDTH=32 and WIDTH=8
module tb_iterative_alu;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  iterative_alu_if #(.WIDTH(32)) i32();
  iterative_alu_if #(.WIDTH(8)) i8();
  iterative_alu #(.WIDTH(32)) u32 (.clock(clock), .reset(reset), .bus(i32));
  iterative_alu #(.WIDTH(8)) u8 (.clock(clock), .reset(reset), .bus(i8));
  always #5 clock = ~clock;
  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int busy, input string tag);
    int n;
    @(negedge clock);
    chk(64'(i32.in_ready), 64'd1, {tag, "_in_ready"});
    i32.operation = op;
    i32.operand_1 = a;
    i32.operand_2 = b;
    i32.in_valid = 1'b1;
    @(posedge clock);
    #1;
    i32.in_valid = 1'b0;
    i32.operation = 5'd1;
    i32.operand_1 = ~a;
    i32.operand_2 = ~b;
    n = 0;
    while (!i32.out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(64'(n), 64'(busy), {tag, "_busy_cycles"});
    chk(64'(i32.result), 64'(exp), {tag, "_result"});
    @(negedge clock);
    i32.out_ready = 1'b1;
    @(posedge clock);
    #1;
    i32.out_ready = 1'b0;
    chk(64'(i32.out_valid), 64'd0, {tag, "_consumed"});
  endtask
  task automatic run8(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp, input int busy, input string tag);
    int n;
    @(negedge clock);
    i8.operation = op;
    i8.operand_1 = a;
    i8.operand_2 = b;
    i8.in_valid = 1'b1;
    @(posedge clock);
    #1;
    i8.in_valid = 1'b0;
    i8.operand_1 = ~a;
    n = 0;
    while (!i8.out_valid && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk(64'(n), 64'(busy), {tag, "_busy_cycles"});
    chk(64'(i8.result), 64'(exp), {tag, "_result"});
    @(negedge clock);
    i8.out_ready = 1'b1;
    @(posedge clock);
    #1;
    i8.out_ready = 1'b0;
    chk(64'(i8.out_valid), 64'd0, {tag, "_consumed"});
  endtask
  initial begin
    i32.in_valid = 1'b0; i32.out_ready = 1'b0; i32.operation = '0; i32.operand_1 = '0; i32.operand_2 = '0;
    i8.in_valid = 1'b0; i8.out_ready = 1'b0; i8.operation = '0; i8.operand_1 = '0; i8.operand_2 = '0;
    repeat (2) @(posedge clock);
    #1;
    chk(64'(i32.in_ready), 64'd1, "rst_in_ready");
    chk(64'(i32.out_valid), 64'd0, "rst_out_valid");
    chk(64'(i32.result), 64'd0, "rst_result");
    chk(64'(i8.in_ready), 64'd1, "rst8_in_ready");
    @(negedge clock);
    reset = 1'b0;
    run32(5'd0, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, "add");
    run32(5'd8, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, "or");
    run32(5'd7, 32'h8000_0000, 32'h21, 32'hC000_0000, 0, "sra");
    run32(5'd6, 32'h8000_0000, 32'h21, 32'h4000_0000, 0, "srl");
    run32(5'd2, 32'h1, 32'h24, 32'h10, 0, "sll");
    run32(5'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 0, "sub");
    run32(5'd3, 32'hFFFF_FFFF, 32'h1, 32'h1, 0, "slt");
    run32(5'd4, 32'hFFFF_FFFF, 32'h1, 32'h0, 0, "sltu");
    run32(5'd5, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'hF0F0_F0F0, 0, "xor");
    run32(5'd9, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 0, "and");
    run32(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32, "mulh");
    run32(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32, "mulhu");
    run32(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32, "mulhsu");
    run32(5'd10, 32'd12345, 32'hFFFF_FFFD, 32'hFFFF_6F55, 32, "mul");
    run32(5'd14, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, "div");
    run32(5'd16, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, "rem");
    run32(5'd15, 32'd100, 32'd7, 32'd14, 32, "divu");
    run32(5'd17, 32'd100, 32'd7, 32'd2, 32, "remu");
    run32(5'd14, 32'd9, 32'd0, 32'hFFFF_FFFF, 0, "div_by0");
    run32(5'd16, 32'd5, 32'd0, 32'd5, 0, "rem_by0");
    run32(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, "div_ovf");
    run32(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 0, "rem_ovf");
    run32(5'd20, 32'd3, 32'd4, 32'h0, 0, "invalid");
    @(negedge clock);
    i32.operation = 5'd10; i32.operand_1 = 32'd3; i32.operand_2 = 32'd5; i32.in_valid = 1'b1;
    @(posedge clock);
    #1;
    i32.in_valid = 1'b0;
    repeat (32) @(posedge clock);
    #1;
    chk(64'(i32.out_valid), 64'd1, "bp_out_valid");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      i32.in_valid = i[0];
      i32.operation = 5'd0; i32.operand_1 = 32'd1; i32.operand_2 = 32'd1;
      @(posedge clock);
      #1;
      chk(64'(i32.result), 64'd15, "bp_result_hold");
      chk(64'(i32.in_ready), 64'd0, "bp_in_ready");
    end
    @(negedge clock);
    i32.in_valid = 1'b0;
    i32.out_ready = 1'b1;
    @(posedge clock);
    #1;
    i32.out_ready = 1'b0;
    chk(64'(i32.out_valid), 64'd0, "bp_release_out_valid");
    chk(64'(i32.in_ready), 64'd1, "bp_release_in_ready");
    run32(5'd0, 32'd4, 32'd4, 32'd8, 0, "after_bp");
    @(negedge clock);
    i32.operation = 5'd15; i32.operand_1 = 32'd100; i32.operand_2 = 32'd7; i32.in_valid = 1'b1;
    @(posedge clock);
    #1;
    i32.operation = 5'd0;
    repeat (9) @(posedge clock);
    #1;
    chk(64'(i32.in_ready), 64'd0, "busy_in_ready");
    @(negedge clock);
    i32.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk(64'(i32.in_ready), 64'd1, "abort_in_ready");
    chk(64'(i32.out_valid), 64'd0, "abort_out_valid");
    chk(64'(i32.result), 64'd0, "abort_result");
    @(negedge clock);
    reset = 1'b0;
    run32(5'd0, 32'd2, 32'd3, 32'd5, 0, "add_after_abort");
    run8(5'd13, 8'hFF, 8'hFF, 8'hFE, 8, "w8_mulhu");
    run8(5'd31, 8'h12, 8'h34, 8'h00, 0, "w8_invalid");
    run8(5'd14, 8'hF9, 8'd2, 8'hFD, 8, "w8_div");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/iterative_alu.md
# iterative_alu

Parametrised, handshaked ALU for the tiny RISC-V core that replaces the single-cycle combinational ALU in the execute stage. It executes all RV32I register-register ALU operations in one cycle and adds the M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) using an iterative shift-add multiplier and restoring divider, so area stays small at the cost of WIDTH-cycle latency. A valid/ready handshake on both sides lets the pipeline stall on long operations.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; legal range 4..64.
- SHAMT_WIDTH, $clog2(WIDTH), derived; low bits of operand_2 used as shift amount.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request (high only in IDLE).
- operation  input  5  operation code (encoding below).
- operand_1  input  WIDTH  first operand (rs1).
- operand_2  input  WIDTH  second operand (rs2/immediate).
- out_valid  output  1  result available (high only in DONE).
- out_ready  input  1  consumer takes the result.
- result  output  WIDTH  result; stable while out_valid is high.

## Operation
- Encoding: 0 Add, 1 Subtract, 2 Shift_Left_Logical, 3 Set_Less_Than, 4 Set_Less_Than_Unsigned, 5 Xor, 6 Shift_Right_Logical, 7 Shift_Right_Arithmetic, 8 Or, 9 And, 10 Mul, 11 Mulh, 12 Mulhsu, 13 Mulhu, 14 Div, 15 Divu, 16 Rem, 17 Remu; 18..31 invalid -> result 0.
- Operands, operation captured into internal registers on accept (in_valid && in_ready); inputs ignored afterwards.
- Arithmetic modulo 2^WIDTH; SLT/SLTU result is 0 or 1 zero-extended; shift by operand_2[SHAMT_WIDTH-1:0] only; SRA sign-fills.
- Mul family: unsigned shift-add on operand magnitudes, 2*WIDTH-bit product, one multiplier bit per cycle; signs applied (two's-complement negate of full product) at completion. Mul returns low half; Mulh signed×signed high half; Mulhsu signed operand_1 × unsigned operand_2 high half; Mulhu unsigned high half.
- Div family: restoring division on magnitudes, one quotient bit per cycle; quotient sign = sign1 xor sign2 (signed ops); remainder takes sign of dividend.
- Fast paths (latency 1, no iteration): divisor 0 -> Div/Divu quotient all ones, Rem/Remu remainder = operand_1; signed overflow (operand_1 = most-negative, operand_2 = -1) -> Div quotient = operand_1, Rem remainder 0.
- States: IDLE -> (accept, single-cycle/fast-path/invalid op) DONE; IDLE -> (accept, Mul*/Div* otherwise) BUSY with counter = WIDTH; BUSY: one step per cycle, counter decrements, at count 1 step + sign fix, -> DONE; DONE -> (out_ready) IDLE.
- No accept in the cycle a result is consumed (in_ready low in DONE); back-to-back throughput therefore one op per 2 cycles minimum.

## Timing
- Reset (synchronous, wins over everything including a handshake in the same cycle): state IDLE, in_ready 1, out_valid 0, result 0, counter 0, internal operand registers 0.
- Accept at edge k: single-cycle/fast/invalid ops -> out_valid high from edge k+1.
- Accept at edge k: iterative Mul*/Div* -> out_valid high from edge k+WIDTH (WIDTH cycles in BUSY).
- out_valid and result held indefinitely while out_ready low; consumed at the edge where out_valid && out_ready; in_ready high from the following cycle.
- Reset asserted in BUSY or DONE aborts the operation; no result produced; out_valid 0 next cycle.
- in_valid in BUSY/DONE ignored, no side effects; out_ready in IDLE/BUSY ignored.
- result is registered; no combinational path from any input to any output other than via state.

## Test plan
- WIDTH=32, Add 0x7FFFFFFF+1 -> 0x80000000, out_valid one cycle after accept; Or 0xF0F0_0000|0x0000_0F0F -> 0xF0F00F0F; Sra 0x80000000 by 0x21 (shamt 1) -> 0xC0000000.
- Mulh 0xFFFFFFFF×0xFFFFFFFF -> 0; Mulhu same -> 0xFFFFFFFE; Mulhsu 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF; Mul 12345×-3 -> -37035; each out_valid exactly 32 cycles after accept.
- Div -7/2 -> -3, Rem -7/2 -> -1, Divu 100/7 -> 14, Remu 100/7 -> 2 at latency 32; Div x/0 -> 0xFFFFFFFF, Rem 5/0 -> 5, Div 0x80000000/-1 -> 0x80000000 with Rem 0, all at latency 1.
- Backpressure: Mul result with out_ready low 10 cycles -> result stable, in_ready low, extra in_valid pulses ignored; release -> IDLE next cycle, then new op accepted.
- Reset asserted mid-BUSY (cycle 10 of Div) -> next cycle IDLE, out_valid 0, result 0; following Add 2+3 -> 5 at latency 1.
- WIDTH=8: Mulhu 0xFF×0xFF -> 0xFE at latency 8; invalid op 31 -> result 0 at latency 1.
